// File: rtl/nibble_merge.sv
// ============================================================================
// Module   : nibble_merge
// Purpose  : Packs pairs of 4-bit nibbles into bytes behind a valid/ready
//            handshake on both sides, with a synchronous partial-flush.
// Options  : define NIBBLE_MERGE_PARITY_EN to add the registered out_par port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_merge #(
    parameter int LOW_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_nib,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frag
`ifdef NIBBLE_MERGE_PARITY_EN
    ,
    output logic       out_par
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_held;
    logic [7:0] r_byte;
    logic       r_valid;
    logic       r_frag;
`ifdef NIBBLE_MERGE_PARITY_EN
    logic       r_par;
`endif

    logic       w_nib_xfer;
    logic       w_byte_xfer;
    logic [7:0] w_merged;

    // Ready depends on out_ready only, so a full byte can drain and be
    // replaced by a new first nibble on the same edge.
    assign in_ready    = (r_state != ST_FULL) | out_ready;
    assign w_nib_xfer  = in_valid & in_ready;
    assign w_byte_xfer = r_valid & out_ready;
    assign w_merged    = (LOW_FIRST != 0) ? {in_nib, r_held} : {r_held, in_nib};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_held  <= 4'h0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_frag  <= 1'b0;
`ifdef NIBBLE_MERGE_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_frag <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_nib_xfer) begin
                        r_held  <= in_nib;
                        r_state <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    // Flush wins over completion: a concurrent nibble starts a new byte.
                    if (flush) begin
                        r_frag <= 1'b1;
                        if (w_nib_xfer) begin
                            r_held <= in_nib;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end else if (w_nib_xfer) begin
                        r_byte  <= w_merged;
                        r_valid <= 1'b1;
                        r_state <= ST_FULL;
`ifdef NIBBLE_MERGE_PARITY_EN
                        r_par   <= ^w_merged;
`endif
                    end
                end
                ST_FULL: begin
                    if (w_byte_xfer) begin
                        r_valid <= 1'b0;
                        if (w_nib_xfer) begin
                            r_held  <= in_nib;
                            r_state <= ST_HALF;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_byte  = r_byte;
    assign out_valid = r_valid;
    assign frag      = r_frag;
`ifdef NIBBLE_MERGE_PARITY_EN
    assign out_par   = r_par;
`endif

endmodule

`default_nettype wire

// File: doc/nibble_merge.md
NIBBLE_MERGE -- requirements
Module: nibble_merge

Interface
REQ-001 Parameter: LOW_FIRST, default 1, 1 = first accepted nibble lands in byte bits [3:0] and second in [7:4]; 0 = reversed.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_nib  input  4  nibble data.
REQ-005 Port: in_valid  input  1  in_nib valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts in_nib this cycle.
REQ-007 Port: flush  input  1  synchronous discard of any held partial nibble.
REQ-008 Port: out_byte  output  8  assembled byte.
REQ-009 Port: out_valid  output  1  out_byte valid.
REQ-010 Port: out_ready  input  1  downstream accepts out_byte this cycle.
REQ-011 Port: frag  output  1  one-cycle pulse: flush discarded a held nibble.
REQ-012 Port: out_par  output  1  even parity of out_byte (present only per REQ-030).

Function
REQ-013 Nibble transfer SHALL occur when in_valid and in_ready are both high at a rising edge; byte transfer when out_valid and out_ready are both high.
REQ-014 State machine SHALL have states EMPTY (nothing held), HALF (one nibble held), FULL (byte held, out_valid=1).
REQ-015 EMPTY: nibble transfer -> HALF, nibble stored in first-half position per LOW_FIRST.
REQ-016 HALF: nibble transfer -> FULL; byte formed from held nibble plus current nibble; out_valid asserts the next cycle (latency one cycle from second nibble).
REQ-017 FULL with byte transfer and no nibble transfer -> EMPTY.
REQ-018 FULL with byte transfer and simultaneous nibble transfer -> HALF holding the new nibble; no bubble, full throughput of one nibble per cycle.
REQ-019 FULL without byte transfer: out_byte and out_valid SHALL hold stable; no nibble accepted.
REQ-020 in_ready SHALL equal (state != FULL) or out_ready (combinational from out_ready only).
REQ-021 out_valid SHALL be registered and high exactly in FULL; out_byte SHALL change only on entry to FULL.
REQ-022 flush in HALF: -> EMPTY, held nibble dropped, frag=1 next cycle; a simultaneous nibble transfer SHALL be treated as the first nibble of a new byte (-> HALF with that nibble).
REQ-023 flush in EMPTY: no effect, frag stays 0.
REQ-024 flush in FULL: the completed byte is unaffected; REQ-017/018 apply; frag stays 0.
REQ-025 frag SHALL be a registered single-cycle pulse, 0 otherwise.

Reset
REQ-026 rst_n low SHALL immediately force state EMPTY, out_valid=0, out_byte=8'h00, frag=0, out_par=0, independent of clk.
REQ-027 Reset asserted mid-byte (HALF or FULL) SHALL discard held data without frag pulse.
REQ-028 in_ready SHALL be 1 during and after reset (state EMPTY).
REQ-029 Deassertion of rst_n SHALL take effect at the first clk rising edge after it; no transfer on that edge is lost.

Configuration
REQ-030 Macro NIBBLE_MERGE_PARITY_EN: defined -> out_par port present, registered alongside out_byte, equal to XOR of out_byte bits (byte 8'h07 gives 1); undefined -> out_par port and its logic absent, all other behaviour identical.

Verification
REQ-031 Reset, LOW_FIRST=1, out_ready=1: nibbles 4'h5 then 4'hA on consecutive cycles -> out_byte=8'hA5, out_valid=1 for one cycle, one cycle after second nibble.
REQ-032 LOW_FIRST=0, same stimulus -> out_byte=8'h5A.
REQ-033 Continuous nibbles 1,2,3,4,5,6 with out_ready=1 -> bytes 8'h21, 8'h43, 8'h65 back-to-back on alternate cycles, in_ready never low.
REQ-034 out_ready=0 after byte 8'h21 formed -> in_ready=0, out_byte holds 8'h21 for 10 cycles; out_ready=1 with in_valid=1 nibble 4'h3 -> byte taken and state HALF same edge.
REQ-035 Nibble 4'h9 accepted, then flush=1 with nibble 4'hC, then nibble 4'hD -> frag pulses once, out_byte=8'hDC (9 discarded).
REQ-036 rst_n pulsed low while in HALF, then nibbles 4'h1, 4'h2 -> out_byte=8'h21, frag never asserted; with NIBBLE_MERGE_PARITY_EN, out_par=0.
